// File: rtl/mutation_mask_gen.sv
// mutation_mask_gen: LFSR-driven bank of random bit-flip masks for the mutation stage.
// Builds mutationMaskCount masks (mutationBits distinct set bits each), raises
// maskReady, serves mask[nextFinalSelected*howGrowUp + growIndex], and regenerates
// the bank after a maskUsed rise/fall handshake.
// Ports:
//   CLOCK_50          in   clock, rising edge
//   reset             in   asynchronous, active-low
//   state_controller  in   top-level controller state
//   state_mutationFSM in   consumer FSM state
//   maskUsed          in   consumer is done with the current bank
//   nextFinalSelected in   parent index being mutated
//   maskReady         out  bank complete and frozen
//   growIndex         out  mutant index within the current parent
//   maskIndex         out  selected mask index (8-bit truncated)
//   mutationMask      out  selected mask, zero when maskIndex is out of range
// Optional build macro MASK_GEN_RESEED_EN adds seedLoad/seedValue, which reload
// the LFSR while the bank sits in READY or RELEASE.
module mutation_mask_gen #(
    parameter int unsigned geneBit              = 80,
    parameter int unsigned mutationMaskCount    = 16,
    parameter int unsigned howGrowUp            = 4,
    parameter int unsigned mutationBits         = 3,
    parameter int unsigned posBits              = 7,
    parameter logic [31:0] lfsrSeed             = 32'hACE12D3B,
    parameter logic [2:0]  mutation_controller  = 3'b011,
    parameter logic [3:0]  mutation_mutationFSM = 4'b0001
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [2:0]         state_controller,
    input  logic [3:0]         state_mutationFSM,
    input  logic               maskUsed,
    input  logic [7:0]         nextFinalSelected,
`ifdef MASK_GEN_RESEED_EN
    input  logic               seedLoad,
    input  logic [31:0]        seedValue,
`endif
    output logic               maskReady,
    output logic [7:0]         growIndex,
    output logic [7:0]         maskIndex,
    output logic [geneBit-1:0] mutationMask
);

    localparam int unsigned CNT_W =
        (mutationMaskCount > 1) ? $clog2(mutationMaskCount) : 1;
    localparam int unsigned BIT_W = $clog2(mutationBits + 1);
    localparam int unsigned EXT_W = 1 << posBits;

    localparam logic [31:0]      LFSR_TAPS  = 32'h80200003;
    localparam logic [CNT_W-1:0] LAST_MASK  = CNT_W'(mutationMaskCount - 1);
    localparam logic [BIT_W-1:0] BITS_DONE  = BIT_W'(mutationBits);
    localparam logic [7:0]       GROW_LAST  = 8'(howGrowUp - 1);
    localparam logic [7:0]       GROW_STEP  = 8'(howGrowUp);
    localparam logic [8:0]       MASK_LIMIT = 9'(mutationMaskCount);

    typedef enum logic [2:0] {
        CLEAR,
        GEN_BIT,
        NEXT_MASK,
        READY,
        RELEASE
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        lfsr_q, lfsr_d;
    logic [geneBit-1:0] mask_q [mutationMaskCount];
    logic [geneBit-1:0] mask_d [mutationMaskCount];
    logic [CNT_W-1:0]   mask_cnt_q, mask_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               mask_ready_q, mask_ready_d;
    logic [7:0]         grow_index_q, grow_index_d;

    logic [31:0]        lfsr_step;
    logic [posBits-1:0] pos;
    logic [EXT_W-1:0]   cur_ext;
    logic [EXT_W-1:0]   set_ext;
    logic               pos_ok;
    logic [BIT_W-1:0]   bit_cnt_inc;
    logic               seed_load;
    logic [31:0]        seed_value;
    logic               in_mutation;

`ifdef MASK_GEN_RESEED_EN
    // A zero seed would lock the LFSR, so fall back to the reset seed.
    assign seed_load  = seedLoad;
    assign seed_value = (seedValue == 32'h0) ? lfsrSeed : seedValue;
`else
    assign seed_load  = 1'b0;
    assign seed_value = lfsrSeed;
`endif

    // Galois right-shift step for x^32+x^22+x^2+x+1.
    assign lfsr_step = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);

    // The mask under construction is widened to the full LFSR position range
    // so that any candidate position indexes it safely.
    always_comb begin
        pos         = lfsr_q[posBits-1:0];
        cur_ext     = '0;
        cur_ext[geneBit-1:0] = mask_q[mask_cnt_q];
        set_ext     = cur_ext | (EXT_W'(1) << pos);
        pos_ok      = (32'(pos) < geneBit) && !cur_ext[pos];
        bit_cnt_inc = bit_cnt_q + BIT_W'(1);
    end

    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        mask_d       = mask_q;
        mask_cnt_d   = mask_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        mask_ready_d = mask_ready_q;
        unique case (state_q)
            CLEAR: begin
                mask_d[mask_cnt_q] = '0;
                bit_cnt_d          = '0;
                state_d            = GEN_BIT;
            end
            GEN_BIT: begin
                lfsr_d = lfsr_step;
                // Rejected positions simply cost one more LFSR step.
                if (pos_ok) begin
                    mask_d[mask_cnt_q] = set_ext[geneBit-1:0];
                    bit_cnt_d          = bit_cnt_inc;
                    if (bit_cnt_inc == BITS_DONE) begin
                        state_d = NEXT_MASK;
                    end
                end
            end
            NEXT_MASK: begin
                if (mask_cnt_q == LAST_MASK) begin
                    mask_cnt_d   = '0;
                    mask_ready_d = 1'b1;
                    state_d      = READY;
                end else begin
                    mask_cnt_d = mask_cnt_q + CNT_W'(1);
                    state_d    = CLEAR;
                end
            end
            READY: begin
                if (seed_load) begin
                    lfsr_d = seed_value;
                end
                if (maskUsed) begin
                    mask_ready_d = 1'b0;
                    state_d      = RELEASE;
                end
            end
            RELEASE: begin
                if (seed_load) begin
                    lfsr_d = seed_value;
                end
                if (!maskUsed) begin
                    state_d = CLEAR;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    assign in_mutation = (state_controller == mutation_controller) &&
                         (state_mutationFSM == mutation_mutationFSM);

    // growIndex only runs while the consumer is mutating a ready bank,
    // saturating at the last mutant of the parent.
    always_comb begin
        grow_index_d = grow_index_q;
        if (!in_mutation || !mask_ready_q) begin
            grow_index_d = '0;
        end else if (grow_index_q < GROW_LAST) begin
            grow_index_d = grow_index_q + 8'd1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q      <= CLEAR;
            lfsr_q       <= lfsrSeed;
            mask_q       <= '{default: '0};
            mask_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            mask_ready_q <= 1'b0;
            grow_index_q <= '0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            mask_q       <= mask_d;
            mask_cnt_q   <= mask_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            mask_ready_q <= mask_ready_d;
            grow_index_q <= grow_index_d;
        end
    end

    // 8-bit arithmetic gives the truncation of the selected index.
    assign maskIndex    = nextFinalSelected * GROW_STEP + grow_index_q;
    assign mutationMask = ({1'b0, maskIndex} < MASK_LIMIT) ?
                          mask_q[maskIndex[CNT_W-1:0]] : '0;
    assign maskReady    = mask_ready_q;
    assign growIndex    = grow_index_q;

endmodule
